// File: rtl/mastermind_scorer_pkg.sv
// Shared constants, colour/feedback codes and FSM encoding for the Mastermind scorer.
package mastermind_scorer_pkg;

    localparam int COLOR_W  = 3;
    localparam int NUM_PEGS = 4;
    localparam int NUM_ROWS = 6;
    localparam int PEG_BITS = NUM_PEGS * COLOR_W;
    localparam int FB_W     = 2 * NUM_PEGS;

    localparam logic [COLOR_W-1:0] GRAY   = 3'd0;
    localparam logic [COLOR_W-1:0] RED    = 3'd1;
    localparam logic [COLOR_W-1:0] GREEN  = 3'd2;
    localparam logic [COLOR_W-1:0] BLUE   = 3'd3;
    localparam logic [COLOR_W-1:0] YELLOW = 3'd4;
    localparam logic [COLOR_W-1:0] PURPLE = 3'd5;
    localparam logic [COLOR_W-1:0] ORANGE = 3'd6;

    localparam logic [1:0] FB_NONE  = 2'b00;
    localparam logic [1:0] FB_PART  = 2'b01;
    localparam logic [1:0] FB_EXACT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXACT   = 2'd1,
        ST_PARTIAL = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [COLOR_W-1:0] peg_of(input logic [PEG_BITS-1:0] code,
                                                  input logic [1:0]          idx);
        return code[idx*COLOR_W +: COLOR_W];
    endfunction

endpackage

// File: rtl/mastermind_scorer_history.sv
// Per-row feedback history register file; one row is written per completed scoring run.
module mastermind_scorer_history
    import mastermind_scorer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [2:0]                wr_row,
    input  logic [FB_W-1:0]           wr_data,
    output logic [FB_W*NUM_ROWS-1:0]  fb_flat
);

    logic [FB_W*NUM_ROWS-1:0] rows_r;

    // Row storage with synchronous clear; only the addressed row changes on a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_r <= '0;
        end else if (we) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (wr_row == 3'(r)) begin
                    rows_r[r*FB_W +: FB_W] <= wr_data;
                end
            end
        end
    end

    assign fb_flat = rows_r;

endmodule

// File: rtl/mastermind_scorer.sv
// Scores a 4-peg guess against the answer in a fixed number of cycles (exact pass, then
// misplaced pass) and records the per-peg feedback in a row history.
module mastermind_scorer
    import mastermind_scorer_pkg::*;
(
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      start,
    input  logic [2:0]                row,
    input  logic [PEG_BITS-1:0]       guess,
    input  logic [PEG_BITS-1:0]       answer,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                exact_cnt,
    output logic [2:0]                partial_cnt,
    output logic                      win,
    output logic [FB_W-1:0]           peg_fb,
    output logic [FB_W*NUM_ROWS-1:0]  fb_flat
);

    state_t              state_r, state_s;
    logic [1:0]          i_r, j_r;
    logic [PEG_BITS-1:0] guess_r, answer_r;
    logic [2:0]          row_r;
    logic [NUM_PEGS-1:0] used_g_r, used_a_r;
    logic [2:0]          exact_r, partial_r;
    logic [FB_W-1:0]     peg_fb_r;
    logic                busy_r, done_r, win_r;
    logic [COLOR_W-1:0]  g_i_s, a_i_s, a_j_s;
    logic                exact_hit_s, part_hit_s, hist_we_s;

    assign g_i_s = peg_of(guess_r, i_r);
    assign a_i_s = peg_of(answer_r, i_r);
    assign a_j_s = peg_of(answer_r, j_r);

    // Gray is an empty slot and must never score, even against a gray answer peg.
    assign exact_hit_s = (g_i_s != GRAY) && (g_i_s == a_i_s);
    assign part_hit_s  = !used_g_r[i_r] && !used_a_r[j_r] && (g_i_s != GRAY) && (g_i_s == a_j_s);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_EXACT;
                else       state_s = ST_IDLE;
            end
            ST_EXACT: begin
                if (i_r == 2'd3) state_s = ST_PARTIAL;
                else             state_s = ST_EXACT;
            end
            ST_PARTIAL: begin
                if ((i_r == 2'd3) && (j_r == 2'd3)) state_s = ST_DONE;
                else                                state_s = ST_PARTIAL;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Operand latch, match bookkeeping, counters and registered status outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            i_r       <= 2'd0;
            j_r       <= 2'd0;
            guess_r   <= '0;
            answer_r  <= '0;
            row_r     <= 3'd0;
            used_g_r  <= '0;
            used_a_r  <= '0;
            exact_r   <= 3'd0;
            partial_r <= 3'd0;
            peg_fb_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            win_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        guess_r   <= guess;
                        answer_r  <= answer;
                        row_r     <= row;
                        used_g_r  <= '0;
                        used_a_r  <= '0;
                        exact_r   <= 3'd0;
                        partial_r <= 3'd0;
                        peg_fb_r  <= '0;
                        win_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        i_r       <= 2'd0;
                        j_r       <= 2'd0;
                    end
                end
                ST_EXACT: begin
                    if (exact_hit_s) begin
                        peg_fb_r[i_r*2 +: 2] <= FB_EXACT;
                        used_g_r[i_r]        <= 1'b1;
                        used_a_r[i_r]        <= 1'b1;
                        exact_r              <= exact_r + 3'd1;
                    end
                    i_r <= i_r + 2'd1;
                end
                ST_PARTIAL: begin
                    if (part_hit_s) begin
                        peg_fb_r[i_r*2 +: 2] <= FB_PART;
                        used_g_r[i_r]        <= 1'b1;
                        used_a_r[j_r]        <= 1'b1;
                        partial_r            <= partial_r + 3'd1;
                    end
                    j_r <= j_r + 2'd1;
                    if (j_r == 2'd3) begin
                        i_r <= i_r + 2'd1;
                    end
                    if ((i_r == 2'd3) && (j_r == 2'd3)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        win_r  <= (exact_r == 3'(NUM_PEGS));
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // peg_fb is final only after the last misplaced comparison, so the row is stored on leaving DONE.
    assign hist_we_s = (state_r == ST_DONE) && (row_r < 3'(NUM_ROWS));

    mastermind_scorer_history u_history (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (hist_we_s),
        .wr_row  (row_r),
        .wr_data (peg_fb_r),
        .fb_flat (fb_flat)
    );

    assign busy        = busy_r;
    assign done        = done_r;
    assign exact_cnt   = exact_r;
    assign partial_cnt = partial_r;
    assign win         = win_r;
    assign peg_fb      = peg_fb_r;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Table-driven bench for mastermind_scorer with a scoreboard queue of expected results.
module tb_mastermind_scorer;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [2:0]  row;
    logic [11:0] guess;
    logic [11:0] answer;
    logic        busy;
    logic        done;
    logic [2:0]  exact_cnt;
    logic [2:0]  partial_cnt;
    logic        win;
    logic [7:0]  peg_fb;
    logic [47:0] fb_flat;

    typedef struct {
        logic [11:0] guess;
        logic [11:0] answer;
        logic [2:0]  row;
        logic [2:0]  exact;
        logic [2:0]  partial;
        logic        win;
        logic [7:0]  fb;
    } vec_t;

    typedef struct {
        logic [2:0] exact;
        logic [2:0] partial;
        logic       win;
        logic [7:0] fb;
        logic [2:0] row;
    } exp_t;

    vec_t        vecs[7];
    exp_t        sb[$];
    logic [47:0] exp_flat;
    int          n_checks;
    int          n_fail;

    mastermind_scorer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .row         (row),
        .guess       (guess),
        .answer      (answer),
        .busy        (busy),
        .done        (done),
        .exact_cnt   (exact_cnt),
        .partial_cnt (partial_cnt),
        .win         (win),
        .peg_fb      (peg_fb),
        .fb_flat     (fb_flat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one scoring run, optionally pulse a second start at cycle dup_at, and check it.
    task automatic run_vec(input vec_t v, input int dup_at);
        int   cyc;
        int   busy_cnt;
        int   extra_done;
        exp_t e;
        @(negedge Clk);
        guess  = v.guess;
        answer = v.answer;
        row    = v.row;
        start  = 1'b1;
        sb.push_back('{exact: v.exact, partial: v.partial, win: v.win, fb: v.fb, row: v.row});
        @(posedge Clk); #1;
        start  = 1'b0;
        guess  = 12'($urandom);
        answer = 12'($urandom);
        row    = 3'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            start = (cyc == dup_at);
            @(posedge Clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 64'(cyc), 64'd21);
        check("busy_cycles", 64'(busy_cnt), 64'd20);
        check("busy_at_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("exact_cnt", 64'(exact_cnt), 64'(e.exact));
            check("partial_cnt", 64'(partial_cnt), 64'(e.partial));
            check("win", 64'(win), 64'(e.win));
            check("peg_fb", 64'(peg_fb), 64'(e.fb));
            if (e.row < 3'd6) exp_flat[e.row*8 +: 8] = e.fb;
            @(posedge Clk); #1;
            check("done_pulse_width", 64'(done), 64'd0);
            check("win_hold", 64'(win), 64'(e.win));
            check("fb_flat", 64'(fb_flat), 64'(exp_flat));
            if (dup_at > 0) begin
                extra_done = 0;
                for (int k = 0; k < 25; k++) begin
                    @(posedge Clk); #1;
                    if (done) extra_done++;
                end
                check("dup_start_extra_done", 64'(extra_done), 64'd0);
            end
        end
    endtask

    initial begin
        int cyc;
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;
        exp_flat = 48'd0;
        Reset_n  = 1'b0;
        start    = 1'b0;
        row      = 3'd0;
        guess    = 12'd0;
        answer   = 12'd0;

        vecs[0] = '{guess: pk(1,1,1,1), answer: pk(1,1,1,1), row: 3'd0, exact: 3'd4, partial: 3'd0, win: 1'b1, fb: 8'hAA};
        vecs[1] = '{guess: pk(1,2,1,1), answer: pk(1,1,2,3), row: 3'd1, exact: 3'd1, partial: 3'd2, win: 1'b0, fb: 8'h16};
        vecs[2] = '{guess: pk(0,0,0,0), answer: pk(0,0,0,0), row: 3'd2, exact: 3'd0, partial: 3'd0, win: 1'b0, fb: 8'h00};
        vecs[3] = '{guess: pk(4,3,2,1), answer: pk(1,2,3,4), row: 3'd3, exact: 3'd0, partial: 3'd4, win: 1'b0, fb: 8'h55};
        vecs[4] = '{guess: pk(6,5,0,5), answer: pk(5,6,5,6), row: 3'd4, exact: 3'd0, partial: 3'd3, win: 1'b0, fb: 8'h45};
        vecs[5] = '{guess: pk(2,3,2,3), answer: pk(2,2,3,3), row: 3'd5, exact: 3'd2, partial: 3'd2, win: 1'b0, fb: 8'h96};
        vecs[6] = '{guess: pk(3,4,5,6), answer: pk(3,4,5,6), row: 3'd6, exact: 3'd4, partial: 3'd0, win: 1'b1, fb: 8'hAA};

        // Reset state, with start held high to show reset wins.
        start = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_exact", 64'(exact_cnt), 64'd0);
        check("rst_partial", 64'(partial_cnt), 64'd0);
        check("rst_win", 64'(win), 64'd0);
        check("rst_peg_fb", 64'(peg_fb), 64'd0);
        check("rst_fb_flat", 64'(fb_flat), 64'd0);
        start = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v], 0);
        end
        check("history_all_rows", 64'(fb_flat), 64'h9645_5500_16AA);

        // Second start three cycles into a run is ignored; also overwrites row 0.
        run_vec('{guess: pk(1,2,1,1), answer: pk(1,1,2,3), row: 3'd0, exact: 3'd1, partial: 3'd2, win: 1'b0, fb: 8'h16}, 3);
        check("row0_overwritten", 64'(fb_flat[7:0]), 64'h16);

        // Reset mid-run aborts without a done pulse and clears the history.
        @(negedge Clk);
        guess  = pk(1,1,1,1);
        answer = pk(1,1,1,1);
        row    = 3'd2;
        start  = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge Clk); #1;
            cyc++;
        end
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_exact", 64'(exact_cnt), 64'd0);
        check("abort_partial", 64'(partial_cnt), 64'd0);
        check("abort_peg_fb", 64'(peg_fb), 64'd0);
        check("abort_fb_flat", 64'(fb_flat), 64'd0);
        Reset_n  = 1'b1;
        exp_flat = 48'd0;
        sb.delete();
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge Clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        run_vec(vecs[1], 0);
        check("fresh_history", 64'(fb_flat), 64'h0000_0000_1600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
